// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory response block.
package dmem_pkg;

  localparam int N_DEFAULT       = 64;
  localparam int DEPTH_DEFAULT   = 64;
  localparam int LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between an initiator and dmem_resp.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, synchronous clear of every word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [N-1:0]             wdata,
  output logic [N-1:0]             rdata
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: clearing a memory on reset forces it into flops rather than a RAM macro;
  // it is done here only because a cleared image is a functional requirement.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency load/store responder: accepts one request, waits LATENCY cycles, then holds the response.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int           AW         = $clog2(DEPTH);
  localparam logic [N-1:0] ADDR_LIMIT = N'(DEPTH * 8);

  state_t          state;
  logic [3:0]      cnt;
  logic            ready_q;
  logic            valid_q;
  logic [N-1:0]    rdata_q;
  logic            err_q;
  logic            wr_q;
  logic            bad_q;
  logic [AW-1:0]   word_q;
  logic [N-1:0]    wdata_q;

  logic            addr_bad;
  logic            commit;
  logic            mem_we;
  logic [N-1:0]    mem_rdata;

  // The error decision is made on the live address at accept; only the word index is kept.
  assign addr_bad = (bus.req_addr[2:0] != 3'b000) || (bus.req_addr >= ADDR_LIMIT);
  assign commit   = (state == WAIT) && (cnt == 4'd0);
  assign mem_we   = commit && wr_q && !bad_q;

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .clear (!reset),
    .we    (mem_we),
    .addr  (word_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            bad_q   <= addr_bad;
            word_q  <= bus.req_addr[AW+2:3];
            wdata_q <= bus.req_wdata;
            cnt     <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rdata_q <= (bad_q || wr_q) ? '0 : mem_rdata;
            err_q   <= bad_q;
            valid_q <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Response data is left in place after completion; only the handshake drops.
          if (bus.resp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp, checked every cycle against a transaction-level memory model.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int N       = 64;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dmem_if #(.N(N)) bus ();

  dmem_resp #(
    .N       (N),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit addr_bad(input logic [63:0] a);
    return (a % 8 != 0) || (a >= 64'(DEPTH * 8));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a / 8) % DEPTH);
  endfunction

  logic [N-1:0] m_mem [DEPTH];
  bit           m_live = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_resp = 1'b0;
  longint       m_edge = 0;
  longint       m_acc_edge = 0;
  logic         m_wr;
  logic [63:0]  m_addr;
  logic [63:0]  m_wdata;
  logic [63:0]  m_rdata;
  logic         m_err;

  // A request is in flight from its accept edge until the edge that takes its response;
  // its effect lands exactly LATENCY edges after acceptance.
  always @(posedge clk) begin
    m_edge <= m_edge + 1;
    if (!reset) begin
      foreach (m_mem[i]) m_mem[i] <= '0;
      m_live  <= 1'b1;
      m_busy  <= 1'b0;
      m_resp  <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
    end else if (!m_busy) begin
      if (bus.req_valid === 1'b1) begin
        m_busy     <= 1'b1;
        m_acc_edge <= m_edge;
        m_wr       <= bus.req_write;
        m_addr     <= bus.req_addr;
        m_wdata    <= bus.req_wdata;
      end
    end else if (!m_resp) begin
      if (m_edge == m_acc_edge + LATENCY) begin
        m_err   <= addr_bad(m_addr);
        m_rdata <= (addr_bad(m_addr) || m_wr) ? 64'd0 : m_mem[word_of(m_addr)];
        if (m_wr && !addr_bad(m_addr)) m_mem[word_of(m_addr)] <= m_wdata;
        m_resp  <= 1'b1;
      end
    end else if (bus.resp_ready === 1'b1) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("req_ready", 64'(bus.req_ready), 64'(!m_busy));
      check("resp_valid", 64'(bus.resp_valid), 64'(m_resp));
      if (m_resp) begin
        check("resp_rdata", bus.resp_rdata, m_rdata);
        check("resp_err", 64'(bus.resp_err), 64'(m_err));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input int bp, output logic [63:0] rdata, output logic err,
                        output int lat);
    int guard;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.resp_ready = 1'b0;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      check("accept_wait", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (bp == 0) bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      check("resp_wait", 64'(bus.resp_valid), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(bus.resp_valid), 64'd1);
      check("bp_rdata_hold", bus.resp_rdata, rdata);
      check("bp_err_hold", 64'(bus.resp_err), 64'(err));
      check("bp_no_accept", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_err", 64'(bus.resp_err), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(bus.req_ready), 64'd1);
    check("idle_valid", 64'(bus.resp_valid), 64'd0);
    check("idle_rdata", bus.resp_rdata, 64'd0);
    check("idle_err", 64'(bus.resp_err), 64'd0);

    // Store then load the same word.
    do_req(1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, 0, rd, er, lat);
    check("st10_err", 64'(er), 64'd0);
    check("st10_rdata", rd, 64'd0);
    check("st10_lat", 64'(lat), 64'd2);
    check("model_word2", m_mem[2], 64'h0000_0000_DEAD_BEEF);
    do_req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    check("ld10_rdata", rd, 64'h0000_0000_DEAD_BEEF);
    check("ld10_err", 64'(er), 64'd0);
    check("ld10_lat", 64'(lat), 64'd2);

    // Misaligned store must not disturb memory.
    do_req(1'b1, 64'h13, 64'h55, 0, rd, er, lat);
    check("st13_err", 64'(er), 64'd1);
    check("st13_rdata", rd, 64'd0);
    do_req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    check("ld10_after_bad", rd, 64'h0000_0000_DEAD_BEEF);

    // Range boundary: 0x200 is the first illegal byte address, 0x1F8 the last legal word.
    do_req(1'b0, 64'h200, 64'h0, 0, rd, er, lat);
    check("ld200_err", 64'(er), 64'd1);
    check("ld200_rdata", rd, 64'd0);
    do_req(1'b1, 64'h1F8, 64'hA5A5_5A5A_0123_4567, 0, rd, er, lat);
    check("st1f8_err", 64'(er), 64'd0);
    do_req(1'b0, 64'h1F8, 64'h0, 0, rd, er, lat);
    check("ld1f8_rdata", rd, 64'hA5A5_5A5A_0123_4567);

    // Upper address bits only feed the range check: no aliasing onto word 2.
    do_req(1'b1, 64'h1_0000_0010, 64'h1111_2222_3333_4444, 0, rd, er, lat);
    check("st_hi_err", 64'(er), 64'd1);
    do_req(1'b0, 64'h1_0000_0010, 64'h0, 0, rd, er, lat);
    check("ld_hi_err", 64'(er), 64'd1);
    check("ld_hi_rdata", rd, 64'd0);
    do_req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    check("ld10_after_hi", rd, 64'h0000_0000_DEAD_BEEF);
    do_req(1'b0, 64'h0, 64'h0, 0, rd, er, lat);
    check("ld0_cleared", rd, 64'd0);

    // Backpressure with req_valid held high throughout.
    do_req(1'b0, 64'h10, 64'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 64'h0000_0000_DEAD_BEEF);
    check("bp_lat", 64'(lat), 64'd2);
    @(negedge clk);
    check("bp_back_idle", 64'(bus.req_ready), 64'd1);

    // Reset during WAIT aborts the store; reset also clears the whole array.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h8;
    bus.req_wdata = 64'h77;
    @(negedge clk);
    check("abort_in_wait", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    do_req(1'b0, 64'h8, 64'h0, 0, rd, er, lat);
    check("ld8_after_abort", rd, 64'd0);
    check("ld8_err", 64'(er), 64'd0);
    do_req(1'b0, 64'h10, 64'h0, 0, rd, er, lat);
    check("ld10_after_reset", rd, 64'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
